denormalize: RTL and testbench

Rebuilds a 3-component signed fixed-point vector from a unit direction and a length: `x = nx*length`, `y = ny*length`, `z = nz*length`. It is the inverse of the normalization stage. The physics update uses it to turn a collision-resolved direction plus a scalar speed back into a velocity vector. One shared serial shift-add multiplier processes the three components in turn, with a start/done handshake. The block trades latency for area.

---
 rtl/fixed_pkg.sv | 21 ++
 rtl/denormalize_if.sv | 31 +++
 rtl/serial_mul.sv | 45 ++++
 rtl/denormalize.sv | 255 +++++++++++++++++++++++++
 tb/tb_denormalize.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions: default word format, controller states and
// saturation limits for the default Q2.30 word.
package fixed_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_FRAC_WIDTH = 30;

    // Saturation limits for a DEF_WIDTH-bit two's complement word
    localparam logic [DEF_WIDTH-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [DEF_WIDTH-1:0] SAT_MIN = 32'h8000_0000;

    // Controller states: one multiply pass per vector component
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL_X = 3'd1,
        ST_MUL_Y = 3'd2,
        ST_MUL_Z = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/denormalize_if.sv
// Request/result bundle of the denormalize block. The master side issues the
// direction and length and the slave side returns the rebuilt vector.
interface denormalize_if
    import fixed_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] nx;
    logic [WIDTH-1:0] ny;
    logic [WIDTH-1:0] nz;
    logic [WIDTH-1:0] length;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
    logic             overflow;

    modport master (
        output start, nx, ny, nz, length,
        input  busy, done, x, y, z, overflow
    );

    modport slave (
        input  start, nx, ny, nz, length,
        output busy, done, x, y, z, overflow
    );

endinterface

// File: rtl/serial_mul.sv
// LSB-first shift-add unsigned multiplier. The load edge already consumes
// multiplier bit 0, so the full product is held in the accumulator after
// WIDTH edges counted from the load edge. Once the multiplier is exhausted
// further steps add nothing and the product stays stable until reloaded.
module serial_mul
    import fixed_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;

    // Load operands (processing bit 0 at once) or perform one shift-add step
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
        end else if (load) begin
            acc_r    <= b[0] ? {{WIDTH{1'b0}}, a} : {(2*WIDTH){1'b0}};
            mcand_r  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier_r <= {1'b0, b[WIDTH-1:1]};
        end else begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end else begin
                acc_r <= acc_r;
            end
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
        end
    end

    assign product = acc_r;

endmodule

// File: rtl/denormalize.sv
// Rebuilds a signed fixed-point vector from a unit direction and a length.
// A single serial multiplier is time-shared across x, y and z; each component
// takes WIDTH cycles, then the magnitude is truncated, signed and saturated.
module denormalize
    import fixed_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int FRAC_WIDTH = DEF_FRAC_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    denormalize_if.slave bus
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam int               MAG_W    = 2*WIDTH - FRAC_WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);
    localparam logic [WIDTH-1:0] SAT_HI   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_LO   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [MAG_W-1:0] POS_LIM  = MAG_W'(SAT_HI);
    localparam logic [MAG_W-1:0] NEG_LIM  = MAG_W'(SAT_LO);

    // Unsigned magnitude; the most negative value maps onto 2^(WIDTH-1)
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] res;
        if (v[WIDTH-1]) begin
            res = ~v + WIDTH'(1);
        end else begin
            res = v;
        end
        return res;
    endfunction

    // Truncate, apply sign and saturate; returns {overflow, value}
    function automatic logic [WIDTH:0] shape_result(input logic neg,
                                                    input logic [2*WIDTH-1:0] prod);
        logic [MAG_W-1:0] m;
        logic [WIDTH:0]   res;
        m = prod[2*WIDTH-1:FRAC_WIDTH];
        if (neg) begin
            if (m > NEG_LIM) begin
                res = {1'b1, SAT_LO};
            end else begin
                res = {1'b0, (~m[WIDTH-1:0]) + WIDTH'(1)};
            end
        end else begin
            if (m > POS_LIM) begin
                res = {1'b1, SAT_HI};
            end else begin
                res = {1'b0, m[WIDTH-1:0]};
            end
        end
        return res;
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   ny_mag_r;
    logic [WIDTH-1:0]   nz_mag_r;
    logic [WIDTH-1:0]   len_mag_r;
    logic               neg_x_r;
    logic               neg_y_r;
    logic               neg_z_r;
    logic [WIDTH-1:0]   x_r;
    logic [WIDTH-1:0]   y_r;
    logic [WIDTH-1:0]   z_r;
    logic               overflow_r;
    logic               busy_r;
    logic               done_r;

    logic               accept_s;
    logic               last_s;
    logic               mul_load_s;
    logic [WIDTH-1:0]   mul_a_s;
    logic [WIDTH-1:0]   mul_b_s;
    logic [2*WIDTH-1:0] product_s;
    logic               wr_x_s;
    logic               wr_y_s;
    logic               wr_z_s;
    logic               cur_neg_s;
    logic [WIDTH:0]     shaped_s;

    assign accept_s = (state_r == ST_IDLE) && bus.start;
    assign last_s   = (cnt_r == CNT_LAST);
    assign shaped_s = shape_result(cur_neg_s, product_s);

    serial_mul #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load_s),
        .a       (mul_a_s),
        .b       (mul_b_s),
        .product (product_s)
    );

    // Next-state, multiplier reload and result write strobes
    always_comb begin
        state_next_s = state_r;
        mul_load_s   = 1'b0;
        mul_a_s      = {WIDTH{1'b0}};
        mul_b_s      = len_mag_r;
        wr_x_s       = 1'b0;
        wr_y_s       = 1'b0;
        wr_z_s       = 1'b0;
        cur_neg_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next_s = ST_MUL_X;
                    mul_load_s   = 1'b1;
                    mul_a_s      = magnitude(bus.nx);
                    mul_b_s      = magnitude(bus.length);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL_X: begin
                cur_neg_s = neg_x_r;
                if (last_s) begin
                    state_next_s = ST_MUL_Y;
                    wr_x_s       = 1'b1;
                    mul_load_s   = 1'b1;
                    mul_a_s      = ny_mag_r;
                end else begin
                    state_next_s = ST_MUL_X;
                end
            end
            ST_MUL_Y: begin
                cur_neg_s = neg_y_r;
                if (last_s) begin
                    state_next_s = ST_MUL_Z;
                    wr_y_s       = 1'b1;
                    mul_load_s   = 1'b1;
                    mul_a_s      = nz_mag_r;
                end else begin
                    state_next_s = ST_MUL_Y;
                end
            end
            ST_MUL_Z: begin
                cur_neg_s = neg_z_r;
                if (last_s) begin
                    state_next_s = ST_DONE;
                    wr_z_s       = 1'b1;
                end else begin
                    state_next_s = ST_MUL_Z;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Per-component cycle counter, restarted on every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_next_s != state_r) || (state_r == ST_IDLE)) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Operand capture on an accepted start; nx goes straight into the multiplier
    always_ff @(posedge clk) begin
        if (rst) begin
            ny_mag_r  <= {WIDTH{1'b0}};
            nz_mag_r  <= {WIDTH{1'b0}};
            len_mag_r <= {WIDTH{1'b0}};
            neg_x_r   <= 1'b0;
            neg_y_r   <= 1'b0;
            neg_z_r   <= 1'b0;
        end else if (accept_s) begin
            ny_mag_r  <= magnitude(bus.ny);
            nz_mag_r  <= magnitude(bus.nz);
            len_mag_r <= magnitude(bus.length);
            neg_x_r   <= bus.nx[WIDTH-1] ^ bus.length[WIDTH-1];
            neg_y_r   <= bus.ny[WIDTH-1] ^ bus.length[WIDTH-1];
            neg_z_r   <= bus.nz[WIDTH-1] ^ bus.length[WIDTH-1];
        end else begin
            ny_mag_r  <= ny_mag_r;
            nz_mag_r  <= nz_mag_r;
            len_mag_r <= len_mag_r;
            neg_x_r   <= neg_x_r;
            neg_y_r   <= neg_y_r;
            neg_z_r   <= neg_z_r;
        end
    end

    // Result registers and sticky overflow, written at the end of each pass
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r        <= {WIDTH{1'b0}};
            y_r        <= {WIDTH{1'b0}};
            z_r        <= {WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else if (accept_s) begin
            overflow_r <= 1'b0;
        end else if (wr_x_s || wr_y_s || wr_z_s) begin
            if (wr_x_s) begin
                x_r <= shaped_s[WIDTH-1:0];
            end else begin
                x_r <= x_r;
            end
            if (wr_y_s) begin
                y_r <= shaped_s[WIDTH-1:0];
            end else begin
                y_r <= y_r;
            end
            if (wr_z_s) begin
                z_r <= shaped_s[WIDTH-1:0];
            end else begin
                z_r <= z_r;
            end
            overflow_r <= overflow_r | shaped_s[WIDTH];
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Registered status flags derived from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.x        = x_r;
    assign bus.y        = y_r;
    assign bus.z        = z_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_denormalize.sv
// Directed bench for denormalize: hand-computed Q2.30 vectors, latency,
// saturation boundaries, ignored starts and mid-operation reset.
module tb_denormalize;
    import fixed_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    denormalize_if #(.WIDTH(32)) bus ();

    denormalize #(.WIDTH(32), .FRAC_WIDTH(30)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One idle cycle, then present a start; returns cycles from the start edge to done
    task automatic run_op(input logic [31:0] vx, input logic [31:0] vy,
                          input logic [31:0] vz, input logic [31:0] vl, output int lat);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.nx = vx; bus.ny = vy; bus.nz = vz; bus.length = vl;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.nx = 32'h1234_5678; bus.ny = 32'h8765_4321; bus.nz = 32'h0F0F_0F0F; bus.length = 32'h7777_7777;
        lat = 1;
        while (!bus.done && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.start = 1'b0;
        bus.nx = 32'h0; bus.ny = 32'h0; bus.nz = 32'h0; bus.length = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.overflow); end
        total++; if ({bus.x, bus.y, bus.z} !== 96'h0) begin bad++; $display("FAIL reset_xyz got=%h %h %h want=0", bus.x, bus.y, bus.z); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat;
        run_op(32'h2000_0000, 32'hE000_0000, 32'h0000_0000, 32'h6000_0000, lat);
        total++; if (lat !== 97) begin bad++; $display("FAIL basic_latency got=%0d want=97", lat); end
        total++; if (bus.x !== 32'h3000_0000) begin bad++; $display("FAIL basic_x got=%h want=30000000", bus.x); end
        total++; if (bus.y !== 32'hD000_0000) begin bad++; $display("FAIL basic_y got=%h want=d0000000", bus.y); end
        total++; if (bus.z !== 32'h0000_0000) begin bad++; $display("FAIL basic_z got=%h want=0", bus.z); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b want=0", bus.overflow); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy_done got=%b want=1", bus.busy); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", bus.done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_idle got=%b want=0", bus.busy); end
        total++; if (bus.x !== 32'h3000_0000) begin bad++; $display("FAIL basic_x_held got=%h want=30000000", bus.x); end
    endtask

    task automatic test_saturate;
        int lat;
        run_op(32'h7FFF_FFFF, 32'h4000_0000, 32'h8000_0000, 32'h7FFF_FFFF, lat);
        total++; if (lat !== 97) begin bad++; $display("FAIL sat_latency got=%0d want=97", lat); end
        total++; if (bus.x !== SAT_MAX) begin bad++; $display("FAIL sat_x got=%h want=%h", bus.x, SAT_MAX); end
        total++; if (bus.y !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_y got=%h want=7fffffff", bus.y); end
        total++; if (bus.z !== SAT_MIN) begin bad++; $display("FAIL sat_z got=%h want=%h", bus.z, SAT_MIN); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b want=1", bus.overflow); end
    endtask

    task automatic test_boundary;
        int lat;
        // -2.0 * 1.0 lands exactly on the negative limit without saturating
        run_op(32'h8000_0000, 32'h4000_0000, 32'hC000_0000, 32'h4000_0000, lat);
        total++; if (bus.x !== 32'h8000_0000) begin bad++; $display("FAIL bnd_neg_x got=%h want=80000000", bus.x); end
        total++; if (bus.y !== 32'h4000_0000) begin bad++; $display("FAIL bnd_neg_y got=%h want=40000000", bus.y); end
        total++; if (bus.z !== 32'hC000_0000) begin bad++; $display("FAIL bnd_neg_z got=%h want=c0000000", bus.z); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL bnd_neg_ovf got=%b want=0", bus.overflow); end
        // -2.0 * -1.0 = +2.0 is one past the positive limit
        run_op(32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 32'hC000_0000, lat);
        total++; if (bus.x !== SAT_MAX) begin bad++; $display("FAIL bnd_pos_x got=%h want=%h", bus.x, SAT_MAX); end
        total++; if (bus.z !== 32'hC000_0000) begin bad++; $display("FAIL bnd_pos_z got=%h want=c0000000", bus.z); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL bnd_pos_ovf got=%b want=1", bus.overflow); end
    endtask

    task automatic test_truncate;
        int lat;
        run_op(32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h6000_0000, lat);
        total++; if (bus.x !== 32'h0000_0001) begin bad++; $display("FAIL trunc_x got=%h want=00000001", bus.x); end
        total++; if (bus.y !== 32'hFFFF_FFFF) begin bad++; $display("FAIL trunc_y got=%h want=ffffffff", bus.y); end
        total++; if (bus.z !== 32'hFFFF_FFFC) begin bad++; $display("FAIL trunc_z got=%h want=fffffffc", bus.z); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL trunc_ovf got=%b want=0", bus.overflow); end
    endtask

    task automatic test_zero_length;
        int lat;
        run_op(32'h7FFF_FFFF, 32'h4000_0000, 32'h8000_0000, 32'h7FFF_FFFF, lat);
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL zero_pre_ovf got=%b want=1", bus.overflow); end
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h0000_0000, lat);
        total++; if ({bus.x, bus.y, bus.z} !== 96'h0) begin bad++; $display("FAIL zero_xyz got=%h %h %h want=0", bus.x, bus.y, bus.z); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL zero_ovf got=%b want=0", bus.overflow); end
        run_op(32'h4000_0000, 32'hC000_0000, 32'h1000_0000, 32'hA000_0000, lat);
        total++; if (bus.x !== 32'hA000_0000) begin bad++; $display("FAIL follow_x got=%h want=a0000000", bus.x); end
        total++; if (bus.y !== 32'h6000_0000) begin bad++; $display("FAIL follow_y got=%h want=60000000", bus.y); end
        total++; if (bus.z !== 32'hE800_0000) begin bad++; $display("FAIL follow_z got=%h want=e8000000", bus.z); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL follow_ovf got=%b want=0", bus.overflow); end
    endtask

    task automatic test_start_ignored;
        int ndone;
        int done_at;
        int lat;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.nx = 32'h2000_0000; bus.ny = 32'hE000_0000; bus.nz = 32'h0000_0000; bus.length = 32'h6000_0000;
        @(posedge clk); #1;
        ndone = 0; done_at = -1;
        for (int k = 0; k < 97; k++) begin
            if (bus.done) begin ndone++; done_at = k; end
            bus.start = (k == 10 || k == 96);
            bus.nx = 32'h7FFF_FFFF; bus.ny = 32'h7FFF_FFFF; bus.nz = 32'h8000_0000; bus.length = 32'h7FFF_FFFF;
            @(posedge clk); #1;
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", ndone); end
        total++; if (done_at !== 96) begin bad++; $display("FAIL ign_done_cycle got=%0d want=96", done_at); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL ign_done_after got=%b want=0", bus.done); end
        total++; if (bus.x !== 32'h3000_0000) begin bad++; $display("FAIL ign_x got=%h want=30000000", bus.x); end
        total++; if (bus.y !== 32'hD000_0000) begin bad++; $display("FAIL ign_y got=%h want=d0000000", bus.y); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ign_ovf got=%b want=0", bus.overflow); end
        // Two cycles after done: must be accepted
        bus.start = 1'b1;
        bus.nx = 32'h8000_0000; bus.ny = 32'h4000_0000; bus.nz = 32'hC000_0000; bus.length = 32'h4000_0000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", bus.busy); end
        lat = 1;
        while (!bus.done && lat < 300) begin @(posedge clk); #1; lat++; end
        total++; if (lat !== 97) begin bad++; $display("FAIL b2b_latency got=%0d want=97", lat); end
        total++; if (bus.x !== 32'h8000_0000) begin bad++; $display("FAIL b2b_x got=%h want=80000000", bus.x); end
        total++; if (bus.z !== 32'hC000_0000) begin bad++; $display("FAIL b2b_z got=%h want=c0000000", bus.z); end
    endtask

    task automatic test_reset_mid;
        int ndone;
        int lat;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.nx = 32'h7FFF_FFFF; bus.ny = 32'h4000_0000; bus.nz = 32'h8000_0000; bus.length = 32'h7FFF_FFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_pre got=%b want=1", bus.busy); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL rmid_ovf_pre got=%b want=1", bus.overflow); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", bus.busy); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rmid_ovf got=%b want=0", bus.overflow); end
        total++; if ({bus.x, bus.y, bus.z} !== 96'h0) begin bad++; $display("FAIL rmid_xyz got=%h %h %h want=0", bus.x, bus.y, bus.z); end
        bus.start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.start = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_start_busy got=%b want=0", bus.busy); end
        ndone = 0;
        for (int k = 0; k < 150; k++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL rmid_no_done got=%0d want=0", ndone); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_idle got=%b want=0", bus.busy); end
        run_op(32'h2000_0000, 32'hE000_0000, 32'h0000_0000, 32'h6000_0000, lat);
        total++; if (lat !== 97) begin bad++; $display("FAIL rmid_new_latency got=%0d want=97", lat); end
        total++; if (bus.x !== 32'h3000_0000) begin bad++; $display("FAIL rmid_new_x got=%h want=30000000", bus.x); end
        total++; if (bus.y !== 32'hD000_0000) begin bad++; $display("FAIL rmid_new_y got=%h want=d0000000", bus.y); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_saturate();
        test_boundary();
        test_truncate();
        test_zero_length();
        test_start_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
